// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_pkg
// Description : Shared definitions for the ASCII grid loader: the character
//               codes the parser recognises and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

  // Recognised ASCII codes
  localparam logic [7:0] CH_PAPER = 8'h40;  // '@'  cell holding paper
  localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'  empty cell
  localparam logic [7:0] CH_LF    = 8'h0A;  // '\n' end of row
  localparam logic [7:0] CH_CR    = 8'h0D;  // '\r' tolerated, never meaningful

  // Loader state machine
  typedef enum logic [1:0] {
    LOAD  = 2'd0,  // parsing bytes into the matrix
    DRAIN = 2'd1,  // frame already malformed, discarding until in_last
    HOLD  = 2'd2   // grid presented, waiting for grid_ack
  } state_e;

endpackage : grid_pkg
`default_nettype wire

// File: rtl/grid_char_decode.sv
`default_nettype none
// ============================================================================
// Module      : grid_char_decode
// Description : Combinational classifier for one ASCII byte of the grid
//               stream. Exactly one of is_cell / is_lf / is_ignore / is_bad
//               is high for any byte.
// Ports       : in_data   - byte to classify
//               is_cell   - byte is '@' or '.'
//               cell_bit  - value to store for a cell ('@' -> 1, '.' -> 0)
//               is_lf     - byte is '\n'
//               is_ignore - byte carries no information ('\r')
//               is_bad    - byte is not part of the grid alphabet
// Revision    : 1.0 - initial release
// ============================================================================
module grid_char_decode
  import grid_pkg::*;
(
  input  logic [7:0] in_data,
  output logic       is_cell,
  output logic       cell_bit,
  output logic       is_lf,
  output logic       is_ignore,
  output logic       is_bad
);

  always_comb begin
    is_cell   = 1'b0;
    cell_bit  = 1'b0;
    is_lf     = 1'b0;
    is_ignore = 1'b0;
    is_bad    = 1'b0;
    case (in_data)
      CH_PAPER: begin
        is_cell  = 1'b1;
        cell_bit = 1'b1;
      end
      CH_EMPTY: is_cell   = 1'b1;
      CH_LF:    is_lf     = 1'b1;
      CH_CR:    is_ignore = 1'b1;
      default:  is_bad    = 1'b1;
    endcase
  end

endmodule : grid_char_decode
`default_nettype wire

// File: rtl/grid_ascii_loader.sv
`default_nettype none
// ============================================================================
// Module      : grid_ascii_loader
// Description : Streaming parser that turns an ASCII grid ('@' paper,
//               '.' empty, '\n' end of row) into a WIDTH x DEPTH bit matrix,
//               validates the frame shape and holds the result until the
//               consumer acknowledges it.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid/in_data     - byte stream, one byte per transfer
//               in_last              - marks the final byte of a frame
//               in_ready             - byte accepted this cycle (state only)
//               grid_out             - bit r*WIDTH+c = row r, column c
//               grid_valid           - grid_out / err complete and stable
//               grid_ack             - consumer done, honoured in HOLD only
//               err                  - frame was malformed (with grid_valid)
//               rows_loaded          - completed rows of the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module grid_ascii_loader
  import grid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [WIDTH*DEPTH-1:0]     grid_out,
  output logic                       grid_valid,
  input  logic                       grid_ack,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] rows_loaded
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(DEPTH + 1);
  localparam int CELLS = WIDTH * DEPTH;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q,   col_d;
  logic [ROW_W-1:0]   rows_q,  rows_d;
  logic [CELLS-1:0]   grid_q,  grid_d;
  logic               err_q,   err_d;

  // --------------------------------------------------------------------------
  // Byte classification
  // --------------------------------------------------------------------------
  logic is_cell;
  logic cell_bit;
  logic is_lf;
  logic is_ignore;
  logic is_bad;

  grid_char_decode u_decode (
    .in_data   (in_data),
    .is_cell   (is_cell),
    .cell_bit  (cell_bit),
    .is_lf     (is_lf),
    .is_ignore (is_ignore),
    .is_bad    (is_bad)
  );

  logic             xfer;
  logic             byte_err;
  logic [IDX_W-1:0] cell_idx;

  assign in_ready = (state_q != HOLD);
  assign xfer     = in_valid & in_ready;

  // Only consumed when col_q < WIDTH and rows_q < DEPTH, so the truncating
  // cast never aliases a real write.
  assign cell_idx = IDX_W'(rows_q * WIDTH + col_q);

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rows_d   = rows_q;
    grid_d   = grid_q;
    err_d    = err_q;
    byte_err = 1'b0;

    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (is_cell) begin
            if ((col_q < COL_FULL) && (rows_q < ROW_FULL)) begin
              grid_d[cell_idx] = cell_bit;
              col_d            = col_q + 1'b1;
            end else begin
              byte_err = 1'b1;  // row too long, or one row too many
            end
          end else if (is_lf) begin
            if (col_q == COL_FULL) begin
              rows_d = rows_q + 1'b1;
              col_d  = '0;
            end else if (col_q != '0) begin
              byte_err = 1'b1;  // short row
            end
            // col_q == 0: blank line, nothing to do
          end else if (is_bad || !is_ignore) begin
            // Anything outside the recognised alphabet is malformed.
            byte_err = 1'b1;
          end

          if (byte_err) begin
            if (in_last) begin
              state_d = HOLD;
              err_d   = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else if (in_last) begin
            // A full final row needs no trailing newline.
            if (col_d == COL_FULL) begin
              rows_d = rows_d + 1'b1;
              col_d  = '0;
            end
            state_d = HOLD;
            err_d   = !((rows_d == ROW_FULL) && (col_d == '0));
          end
        end
      end

      DRAIN: begin
        if (xfer && in_last) begin
          state_d = HOLD;
          err_d   = 1'b1;
        end
      end

      HOLD: begin
        if (grid_ack) begin
          state_d = LOAD;
          col_d   = '0;
          rows_d  = '0;
          grid_d  = '0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = LOAD;
        col_d   = '0;
        rows_d  = '0;
        grid_d  = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      col_q   <= '0;
      rows_q  <= '0;
      grid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      grid_q  <= grid_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grid_out    = grid_q;
  assign grid_valid  = (state_q == HOLD);
  assign err         = err_q;
  assign rows_loaded = rows_q;

endmodule : grid_ascii_loader
`default_nettype wire

// File: tb/tb_grid_ascii_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_ascii_loader
// Description : Directed self-checking bench for grid_ascii_loader. A 4x2
//               instance covers the parsing and handshake cases, a default
//               16x16 instance covers the full-size frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_ascii_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        grid_ack;
  logic        sel;       // 0: small instance, 1: 16x16 instance

  // Small instance (4x2)
  logic        in_valid_s, in_ready_s, grid_valid_s, err_s, grid_ack_s;
  logic [7:0]  grid_out_s;
  logic [1:0]  rows_s;
  // Default instance (16x16)
  logic        in_valid_l, in_ready_l, grid_valid_l, err_l, grid_ack_l;
  logic [255:0] grid_out_l;
  logic [4:0]  rows_l;

  assign in_valid_s = in_valid & ~sel;
  assign in_valid_l = in_valid &  sel;
  assign grid_ack_s = grid_ack & ~sel;
  assign grid_ack_l = grid_ack &  sel;

  grid_ascii_loader #(.WIDTH(4), .DEPTH(2)) u_dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_s),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready_s),
    .grid_out    (grid_out_s),
    .grid_valid  (grid_valid_s),
    .grid_ack    (grid_ack_s),
    .err         (err_s),
    .rows_loaded (rows_s)
  );

  grid_ascii_loader u_dut_l (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid_l),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready_l),
    .grid_out    (grid_out_l),
    .grid_valid  (grid_valid_l),
    .grid_ack    (grid_ack_l),
    .err         (err_l),
    .rows_loaded (rows_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_low;     // cycles with in_ready low while streaming
  int gv_early;    // cycles with grid_valid high before the final byte

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Streams s one byte per cycle; in_last rides on the final byte if asked.
  // Returns at the falling edge after the final byte was accepted.
  task automatic send(input string s, input bit last_flag);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = last_flag && (i == s.len() - 1);
      #1;
      if (!(sel ? in_ready_l : in_ready_s)) rdy_low++;
      if (sel ? grid_valid_l : grid_valid_s) gv_early++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    grid_ack = 1'b1;
    @(negedge clk);
    grid_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string big;
    logic [7:0] held;
    int hold_bad;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    grid_ack = 1'b0; sel = 1'b0; rdy_low = 0; gv_early = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_grid_valid", grid_valid_s, 0);
    chk("rst_in_ready",   in_ready_s,   1);
    chk("rst_grid_out",   grid_out_s,   0);
    chk("rst_err",        err_s,        0);
    chk("rst_rows",       rows_s,       0);

    // Frame with trailing newline
    send("@.@@\n.@..\n", 1'b1);
    chk("f1_valid", grid_valid_s, 1);
    chk("f1_grid",  grid_out_s,   8'h2D);
    chk("f1_err",   err_s,        0);
    chk("f1_rows",  rows_s,       2);
    chk("f1_ready", in_ready_s,   0);
    ack();
    chk("f1_ack_valid", grid_valid_s, 0);
    chk("f1_ack_grid",  grid_out_s,   0);
    chk("f1_ack_ready", in_ready_s,   1);
    chk("f1_ack_rows",  rows_s,       0);

    // Ack while loading is ignored
    ack();
    chk("stray_ack_valid", grid_valid_s, 0);
    chk("stray_ack_ready", in_ready_s,   1);

    // No trailing newline
    send("@.@@\n.@..", 1'b1);
    chk("f2_valid", grid_valid_s, 1);
    chk("f2_grid",  grid_out_s,   8'h2D);
    chk("f2_err",   err_s,        0);
    chk("f2_rows",  rows_s,       2);
    ack();

    // Short row -> drain -> error
    send("@.@\n....", 1'b1);
    chk("short_valid", grid_valid_s, 1);
    chk("short_err",   err_s,        1);
    ack();

    // Illegal byte, then 5 more bytes, then the last
    rdy_low = 0; gv_early = 0;
    send("X@@@@@", 1'b0);
    send(".", 1'b1);
    chk("bad_rdy_low",  rdy_low,      0);
    chk("bad_gv_early", gv_early,     0);
    chk("bad_valid",    grid_valid_s, 1);
    chk("bad_err",      err_s,        1);
    ack();
    repeat (3) @(negedge clk);
    chk("bad_single_valid", grid_valid_s, 0);

    // CR and blank lines are ignored
    send("\r\n@@@@\r\n\n....\r\n", 1'b1);
    chk("cr_grid", grid_out_s, 8'h0F);
    chk("cr_err",  err_s,      0);
    ack();

    // Too many rows
    send("@@@@\n@@@@\n@", 1'b1);
    chk("extra_row_err", err_s, 1);
    ack();

    // Too many cells in a row
    send("@@@@@\n@@@@", 1'b1);
    chk("long_row_err", err_s, 1);
    ack();

    // Partial final row
    send("@@@@\n@@", 1'b1);
    chk("partial_valid", grid_valid_s, 1);
    chk("partial_err",   err_s,        1);
    chk("partial_rows",  rows_s,       1);
    ack();

    // Hold: bytes offered without ack are refused, grid frozen
    send(".@..\n@..@", 1'b1);
    held = 8'h92;
    hold_bad = 0;
    in_valid = 1'b1; in_data = 8'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready_s !== 1'b0 || grid_out_s !== held || grid_valid_s !== 1'b1) hold_bad++;
    end
    in_valid = 1'b0;
    chk("hold_stable", hold_bad, 0);
    chk("hold_grid",   grid_out_s, 8'h92);
    ack();
    chk("hold_ack_valid", grid_valid_s, 0);
    chk("hold_ack_grid",  grid_out_s,   0);
    chk("hold_ack_ready", in_ready_s,   1);

    // Reset mid-frame discards the partial frame
    send("@@@", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_grid", grid_out_s, 0);
    chk("midrst_rows", rows_s,     0);
    send(".@..\n@..@", 1'b1);
    chk("midrst_f_grid", grid_out_s, 8'h92);
    chk("midrst_f_err",  err_s,      0);
    ack();

    // Full 16x16 frame of paper on the default instance
    sel = 1'b1;
    big = "";
    for (int r = 0; r < 16; r++) big = {big, "@@@@@@@@@@@@@@@@\n"};
    send(big, 1'b1);
    chk("big_valid", grid_valid_l, 1);
    chk("big_grid",  grid_out_l,   {256{1'b1}});
    chk("big_err",   err_l,        0);
    chk("big_rows",  rows_l,       16);
    ack();
    chk("big_ack_grid", grid_out_l, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_grid_ascii_loader
`default_nettype wire

// File: doc/grid_ascii_loader.md
Name: grid_ascii_loader

Overview:
- Streaming front end that parses an ASCII puzzle grid ('@' = paper, '.' = empty, '\n' = end of row) arriving one byte per cycle.
- Builds the WIDTH x DEPTH bit matrix (1 = paper) that the accessibility counter consumes combinationally.
- Validates the grid shape and flags malformed input.
- Holds the finished grid stable until the consumer acknowledges it, then accepts the next frame.

Parameters:
- WIDTH, 16, cells per row (columns)
- DEPTH, 16, rows per grid

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data byte is valid
- in_data  in  8  ASCII byte
- in_last  in  1  qualifies the final byte of the frame; sampled with in_valid
- in_ready  out  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
- grid_out  out  WIDTH*DEPTH  flattened matrix; bit r*WIDTH+c = row r, column c
- grid_valid  out  1  grid_out (and err) are complete and stable
- grid_ack  in  1  consumer has taken the grid; honoured only while grid_valid=1
- err  out  1  frame was malformed; valid only while grid_valid=1
- rows_loaded  out  $clog2(DEPTH+1)  completed rows so far in the current frame

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=LOAD, grid_out=0, grid_valid=0, err=0, rows_loaded=0, column counter=0, in_ready=1.
- States:
  - LOAD (in_ready=1): parse bytes.
  - DRAIN (in_ready=1, error seen): discard bytes until in_last.
  - HOLD (in_ready=0, grid_valid=1): wait for grid_ack.
- Per accepted byte in LOAD:
  - '@' (0x40) or '.' (0x2E) with col<WIDTH and rows<DEPTH: write the bit at [rows][col], then col+1.
  - Cell byte with col==WIDTH or rows==DEPTH: error.
  - '\n' (0x0A) with col==WIDTH: rows+1, col=0.
  - '\n' with col==0: ignored (blank line).
  - '\n' with any other col: error.
  - '\r' (0x0D): ignored.
  - Any other byte: error.
- in_last handling. The in_last byte is processed as above first, then:
  - If col==WIDTH, the row is counted as complete (no trailing newline needed).
  - If total rows==DEPTH and col==0 after this, go to HOLD with err=0.
  - Otherwise go to HOLD with err=1.
- Error mid-frame:
  - If the erroring byte carries in_last, go directly to HOLD with err=1.
  - Otherwise go to DRAIN.
  - DRAIN discards bytes. When in_last is accepted, go to HOLD with err=1.
- Latency: grid_valid rises the cycle after the in_last byte is accepted. grid_out is already final on that cycle.
- HOLD:
  - grid_out, err and rows_loaded are frozen; in_ready=0.
  - On grid_ack: next cycle state=LOAD, grid_valid=0, err=0, grid_out=0, rows_loaded=0, col=0.
  - in_ready is 0 during the ack cycle, so no byte can overlap the ack.
- grid_ack outside HOLD is ignored.
- rst in any state (including mid-frame or HOLD) returns all registers to their reset values on the next edge. A partial frame is discarded.
- Counter widths: col is $clog2(WIDTH+1) bits and rows is $clog2(DEPTH+1) bits, so neither saturates nor wraps; the checks above prevent overflow.
- No combinational path from in_valid to in_ready. in_ready is a function of state only.

Decomposition:
- Shared package grid_pkg:
  - Character constants CH_PAPER=8'h40, CH_EMPTY=8'h2E, CH_LF=8'h0A, CH_CR=8'h0D.
  - State enum {LOAD, DRAIN, HOLD}.
- One sub-module, grid_char_decode: combinational byte -> {is_cell, cell_bit, is_lf, is_ignore, is_bad}.

Test Plan (WIDTH=4, DEPTH=2 unless noted):
- Stream "@.@@\n.@..\n" with in_last on the final '\n' -> grid_valid one cycle later; grid_out=8'b0010_1101 (row0 bits0-3 = 1,0,1,1; row1 = 0,1,0,0); err=0; rows_loaded=2.
- Same frame with no trailing newline, in_last on the final '.' -> identical grid_out, err=0.
- "@.@\n...." with in_last on the final '.' -> short row triggers DRAIN; grid_valid with err=1.
- Byte 'X' in row 0, followed by 5 more bytes, then in_last -> in_ready stays 1 throughout; exactly one grid_valid, with err=1.
- Hold check: after a valid grid, keep in_valid=1 for 10 cycles with no grid_ack -> in_ready=0 and grid_out unchanged. Then pulse grid_ack -> next cycle grid_valid=0, grid_out=0, in_ready=1.
- Reset mid-frame: assert rst after 3 bytes, then send a full valid frame -> only the new frame appears in grid_out.
- Default parameters: 16x16 all-'@' frame -> grid_out all ones.
